// File: rtl/ad9643_spi_ctrl_if.sv
// Register file port between the SPI front end (master) and the register file (slave).
// Purely combinational bundle: read data is a function of reg_addr in the same clk.
// No flow control; the master strobes reg_wr for one clk per written byte.
interface ad9643_spi_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  modport master (output reg_addr, output reg_wr, output reg_wdata, input reg_rdata);
  modport slave  (input reg_addr, input reg_wr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/ad9643_spi_ctrl.sv
// AD9643 SPI slave front end: oversampled SCLK/CSB/SDIO, 16-bit instruction decode, register port sequencing.
// Latency: pin edge seen SYNC_STAGES+1 clk later; write strobe one clk after the 8th data rise.
// No backpressure: clk must run >= 8x SCLK. AD9643_SPI_ADDR_ASCEND_EN selects incrementing addresses.
module ad9643_spi_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_i,
  input  logic csb_i,
  input  logic sdio_i,
  output logic sdio_o,
  output logic sdio_oe_o,
  output logic busy_o,
  output logic frame_err_o,
  ad9643_spi_ctrl_if.master reg_if
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INSTR = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [3:0] LAST_IBIT = 4'd15;
  localparam logic [3:0] LAST_DBIT = 4'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdio_sync_q;
  logic sclk_prev_q;
  logic sclk_s, csb_s, sdio_s, sclk_rise, sclk_fall;

  logic [2:0]        state_q,    state_d;
  logic [3:0]        bit_cnt_q,  bit_cnt_d;
  logic [14:0]       shift_q,    shift_d;
  logic [DATA_W-1:0] tx_q,       tx_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              wr_q,       wr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [1:0]        w_q,        w_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              ld_q,       ld_d;
  logic              oe_q,       oe_d;
  logic              err_q,      err_d;
  logic              armed_q,    armed_d;

  logic [15:0]       instr;
  logic [ADDR_W-1:0] addr_nxt;
  logic              in_unit, unit_done, last_byte;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Incoming bit appended to the bits collected so far, MSB first.
  assign instr = {shift_q, sdio_s};

`ifdef AD9643_SPI_ADDR_ASCEND_EN
  assign addr_nxt = addr_q + 1'b1;
`else
  assign addr_nxt = addr_q - 1'b1;
`endif

  // A unit (instruction or data byte) is in flight; unit_done means this rise completes it.
  assign in_unit   = (state_q == S_INSTR) || (state_q == S_WR) || (state_q == S_RD);
  assign unit_done = sclk_rise &&
                     (((state_q == S_INSTR) && (bit_cnt_q == LAST_IBIT)) ||
                      (((state_q == S_WR) || (state_q == S_RD)) && (bit_cnt_q == LAST_DBIT)));
  assign last_byte = (w_q != 2'b11) && (byte_idx_q == w_q);

  // Synchronize the asynchronous SPI pins and keep the previous sclk for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '0;
      sdio_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], csb_i};
      sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], sdio_i};
      sclk_prev_q <= sclk_s;
    end
  end

  // Frame sequencer: next-state for the FSM, shifters, address and strobes.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    w_d        = w_q;
    byte_idx_d = byte_idx_q;
    ld_d       = 1'b0;
    oe_d       = oe_q;
    err_d      = 1'b0;
    armed_d    = armed_q | csb_s;

    // Address steps only after the write strobe clk, never alongside it.
    if (wr_q) addr_d = addr_nxt;
    if (ld_q) tx_d = reg_if.reg_rdata;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        tx_d      = '0;
        oe_d      = 1'b0;
        // armed_q blocks a frame already running when reset was released.
        if (armed_q && !csb_s) state_d = S_INSTR;
      end
      S_INSTR: begin
        if (sclk_rise) begin
          shift_d = instr[14:0];
          if (bit_cnt_q == LAST_IBIT) begin
            bit_cnt_d  = '0;
            addr_d     = instr[ADDR_W-1:0];
            w_d        = instr[14:13];
            byte_idx_d = '0;
            if (instr[15]) begin
              state_d = S_RD;
              oe_d    = 1'b1;
              ld_d    = 1'b1;
            end else begin
              state_d = S_WR;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_WR: begin
        if (sclk_rise) begin
          shift_d = instr[14:0];
          if (bit_cnt_q == LAST_DBIT) begin
            bit_cnt_d = '0;
            wr_d      = 1'b1;
            wdata_d   = instr[DATA_W-1:0];
            if (last_byte) state_d = S_WAIT;
            else           byte_idx_d = byte_idx_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_RD: begin
        if (sclk_rise) begin
          if (bit_cnt_q == LAST_DBIT) begin
            bit_cnt_d = '0;
            addr_d    = addr_nxt;
            ld_d      = 1'b1;
            if (last_byte) state_d = S_WAIT;
            else           byte_idx_d = byte_idx_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        // The MSB stays put across the fall that follows a reload; later falls advance.
        if (sclk_fall && (bit_cnt_q != 4'd0)) tx_d = {tx_q[DATA_W-2:0], 1'b0};
      end
      S_WAIT: begin
      end
      default: state_d = S_IDLE;
    endcase

    // CSB high ends any frame; a byte completed in this same clk is still honoured.
    if (csb_s) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      if (in_unit && ((bit_cnt_q != 4'd0) || sclk_rise) && !unit_done) err_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      w_q        <= '0;
      byte_idx_q <= '0;
      ld_q       <= 1'b0;
      oe_q       <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      w_q        <= w_d;
      byte_idx_q <= byte_idx_d;
      ld_q       <= ld_d;
      oe_q       <= oe_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
    end
  end

  assign sdio_o           = tx_q[DATA_W-1];
  assign sdio_oe_o        = oe_q;
  assign busy_o           = (state_q != S_IDLE);
  assign frame_err_o      = err_q;
  assign reg_if.reg_addr  = addr_q;
  assign reg_if.reg_wr    = wr_q;
  assign reg_if.reg_wdata = wdata_q;

endmodule

// File: tb/tb_ad9643_spi_ctrl.sv
// Bench for ad9643_spi_ctrl: bit-banged SPI host, register file model, write/read scoreboards.
// Directed frames: writes, stream, read, wrap, abort, reset mid-frame, coincident CSB rise.
// Address direction follows AD9643_SPI_ADDR_ASCEND_EN in the expected-value model.
module tb_ad9643_spi_ctrl;

  logic clk = 1'b0;
  logic reset, sclk, csb, sdio_in, sdio_out, sdio_oe, busy, frame_err;

  always #5 clk = ~clk;

  ad9643_spi_ctrl_if #(.ADDR_W(13), .DATA_W(8)) rif ();

  logic [7:0] mem [0:8191];
  assign rif.reg_rdata = mem[rif.reg_addr];

  ad9643_spi_ctrl #(.ADDR_W(13), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk_i     (sclk),
    .csb_i      (csb),
    .sdio_i     (sdio_in),
    .sdio_o     (sdio_out),
    .sdio_oe_o  (sdio_oe),
    .busy_o     (busy),
    .frame_err_o(frame_err),
    .reg_if     (rif)
  );

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  wr_t wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] tx_bytes [4];
  logic [12:0] prev_addr = '0;
  wr_t wexp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] nxt(input logic [12:0] a);
`ifdef AD9643_SPI_ADDR_ASCEND_EN
    return a + 13'd1;
`else
    return a - 13'd1;
`endif
  endfunction

  // Write scoreboard and pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (rif.reg_wr) begin
      wr_cnt++;
      chk("wr_addr_stable", {19'd0, rif.reg_addr}, {19'd0, prev_addr});
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", wr_q.size(), 1);
      end else begin
        wexp = wr_q.pop_front();
        chk("wr_addr", {19'd0, rif.reg_addr}, {19'd0, wexp.addr});
        chk("wr_data", {24'd0, rif.reg_wdata}, {24'd0, wexp.data});
      end
    end
    prev_addr = rif.reg_addr;
  end

  // One SCLK period; host changes SDIO while SCLK is low and samples just before the rise.
  task automatic spi_bit(input logic b, output logic rb, output logic oe);
    sdio_in = b;
    #80;
    rb = sdio_out;
    oe = sdio_oe;
    sclk = 1'b1;
    #80;
    sclk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    csb = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    csb = 1'b1;
    #160;
  endtask

  task automatic send_bits(input logic [15:0] v, input int from, input int to);
    logic rb, oe;
    for (int i = from; i < to; i++) spi_bit(v[15-i], rb, oe);
  endtask

  // Write frame: instruction, nbytes from tx_bytes (scoreboarded), then extra partial bits.
  task automatic write_frame(input logic [1:0] w, input logic [12:0] a, input int nbytes, input int extra);
    logic [12:0] ea;
    ea = a;
    send_bits({1'b0, w, a}, 0, 16);
    for (int k = 0; k < nbytes; k++) begin
      wr_q.push_back('{addr: ea, data: tx_bytes[k]});
      ea = nxt(ea);
      send_bits({tx_bytes[k], 8'h00}, 0, 8);
    end
    send_bits(16'hFFFF, 0, extra);
  endtask

  // Read frame: expected bytes come from the bench's own memory image.
  task automatic read_frame(input logic [1:0] w, input logic [12:0] a, input int nbytes);
    logic [12:0] ea;
    logic [15:0] iw;
    logic [7:0] got, e;
    logic rb, oe;
    ea = a;
    iw = {1'b1, w, a};
    for (int i = 0; i < 16; i++) begin
      spi_bit(iw[15-i], rb, oe);
      if (i == 15) chk("rd_oe_instr", {31'd0, oe}, 32'd0);
    end
    for (int k = 0; k < nbytes; k++) begin
      rd_q.push_back(mem[ea]);
      ea = nxt(ea);
      for (int i = 0; i < 8; i++) begin
        spi_bit(1'b0, rb, oe);
        got[7-i] = rb;
        if (i == 0) chk("rd_oe_data", {31'd0, oe}, 32'd1);
      end
      e = rd_q.pop_front();
      chk("rd_data", {24'd0, got}, {24'd0, e});
    end
  endtask

  int w0, e0;
  logic rb_t, oe_t;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h00C] = 8'h99;
    mem[13'h00D] = 8'h44;
    mem[13'h00E] = 8'h77;
    reset = 1'b1; csb = 1'b1; sclk = 1'b0; sdio_in = 1'b0;
    repeat (4) @(negedge clk);

    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_sdio",    {31'd0, sdio_out},    32'd0);
    chk("rst_oe",      {31'd0, sdio_oe},     32'd0);
    chk("rst_err",     {31'd0, frame_err},   32'd0);
    chk("rst_wr",      {31'd0, rif.reg_wr},  32'd0);
    chk("rst_addr",    {19'd0, rif.reg_addr}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single-byte write, then WAIT_CS until CSB rises.
    w0 = wr_cnt; e0 = err_cnt;
    tx_bytes[0] = 8'h05;
    cs_low();
    write_frame(2'b00, 13'h00B, 1, 0);
    #200;
    chk("w1_busy_wait", {31'd0, busy}, 32'd1);
    cs_high();
    chk("w1_busy_done", {31'd0, busy}, 32'd0);
    chk("w1_count", wr_cnt - w0, 1);
    chk("w1_no_err", err_cnt - e0, 0);

    // Stream write of four bytes.
    w0 = wr_cnt;
    tx_bytes[0] = 8'hAB; tx_bytes[1] = 8'hCD; tx_bytes[2] = 8'h12; tx_bytes[3] = 8'h34;
    cs_low();
    write_frame(2'b11, 13'h01A, 4, 0);
    chk("stream_busy", {31'd0, busy}, 32'd1);
    cs_high();
    chk("stream_count", wr_cnt - w0, 4);

    // Two-byte read; output enable holds until CSB rises.
    w0 = wr_cnt;
    cs_low();
    read_frame(2'b01, 13'h00D, 2);
    #200;
    chk("rd_oe_wait", {31'd0, sdio_oe}, 32'd1);
    cs_high();
    chk("rd_oe_off", {31'd0, sdio_oe}, 32'd0);
    chk("rd_no_wr", wr_cnt - w0, 0);

    // Address wrap at the bottom (or top) of the 13-bit space.
    w0 = wr_cnt;
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
    cs_low();
    write_frame(2'b01, 13'h0000, 2, 0);
    cs_high();
    chk("wrap_count", wr_cnt - w0, 2);

    // Abort after 5 data bits, then a normal frame.
    w0 = wr_cnt; e0 = err_cnt;
    cs_low();
    write_frame(2'b00, 13'h055, 0, 5);
    cs_high();
    chk("abort_err", err_cnt - e0, 1);
    chk("abort_no_wr", wr_cnt - w0, 0);
    e0 = err_cnt;
    tx_bytes[0] = 8'h5A;
    cs_low();
    write_frame(2'b00, 13'h0AA, 1, 0);
    cs_high();
    chk("post_abort_wr", wr_cnt - w0, 1);
    chk("post_abort_err", err_cnt - e0, 0);

    // Abort mid-instruction.
    e0 = err_cnt;
    cs_low();
    send_bits(16'h0123, 0, 5);
    cs_high();
    chk("instr_abort_err", err_cnt - e0, 1);

    // Reset after 10 instruction bits with CSB held low.
    w0 = wr_cnt;
    cs_low();
    send_bits({3'b000, 13'h100}, 0, 10);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    send_bits({3'b000, 13'h100}, 10, 16);
    send_bits(16'hA500, 0, 8);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_no_wr", wr_cnt - w0, 0);
    cs_high();
    tx_bytes[0] = 8'hC3;
    cs_low();
    write_frame(2'b00, 13'h101, 1, 0);
    cs_high();
    chk("rst_mid_next_wr", wr_cnt - w0, 1);

    // CSB rises together with the 8th data-bit rise: byte still written, no error.
    w0 = wr_cnt; e0 = err_cnt;
    cs_low();
    send_bits({3'b000, 13'h033}, 0, 16);
    wr_q.push_back('{addr: 13'h033, data: 8'h96});
    send_bits(16'h9600, 0, 7);
    sdio_in = 1'b0;
    #80;
    sclk = 1'b1;
    csb = 1'b1;
    #80;
    sclk = 1'b0;
    #160;
    chk("coinc_wr", wr_cnt - w0, 1);
    chk("coinc_no_err", err_cnt - e0, 0);
    chk("coinc_busy", {31'd0, busy}, 32'd0);

    #200;
    chk("sb_empty", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
